// File: rtl/fetch_unit_pkg.sv
// Shared encodings for the fetch unit: sequencer states, opcode field and fetch FSM states.
package fetch_unit_pkg;

  localparam int unsigned SEQ_W   = 6;
  localparam int unsigned IR_W    = 16;
  localparam int unsigned OPC_MSB = 15;
  localparam int unsigned OPC_LSB = 10;
  localparam int unsigned OPC_W   = OPC_MSB - OPC_LSB + 1;

  typedef enum logic [SEQ_W-1:0] {
    SEQ_IDLE   = 6'd0,
    SEQ_FETCH1 = 6'd1,
    SEQ_FETCH2 = 6'd2,
    SEQ_LOAD   = 6'd3,
    SEQ_STORE  = 6'd4,
    SEQ_ADD    = 6'd5,
    SEQ_MUL    = 6'd6
  } seq_state_e;

  localparam logic [OPC_W-1:0] OP_HALT  = 6'd0;
  localparam logic [OPC_W-1:0] OP_LOAD  = 6'd1;
  localparam logic [OPC_W-1:0] OP_STORE = 6'd2;
  localparam logic [OPC_W-1:0] OP_ADD   = 6'd3;
  localparam logic [OPC_W-1:0] OP_MUL   = 6'd4;
  localparam logic [OPC_W-1:0] OP_JMP   = 6'd5;

  typedef enum logic [1:0] {
    F_IDLE = 2'd0,
    F_REQ  = 2'd1,
    F_DONE = 2'd2
  } fetch_state_e;

  function automatic logic [OPC_W-1:0] opcode_of(input logic [IR_W-1:0] word);
    return word[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/fetch_unit_timeout_ctr.sv
// Wait counter for an outstanding fetch; expired_c flags the last allowed wait cycle.
module fetch_timeout_ctr #(
  parameter int unsigned TIMEOUT_CYC = 15
) (
  input  logic clock,
  input  logic rst_n,
  input  logic run,
  output logic expired_c
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n)   cnt_q <= '0;
    else if (run) cnt_q <= cnt_q + CNT_W'(1);
    else          cnt_q <= '0;
  end

  // Counter holds k-1 during the k-th wait cycle, so the abort lands on the TIMEOUT_CYC-th edge.
  assign expired_c = run && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: one program-memory read per fetch1, PC increment, IR capture.
// Optional fetch timeout with sticky fetch_err is enabled by defining FETCH_TIMEOUT_EN.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned TIMEOUT_CYC = 15
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic [5:0]        state,
  input  logic              pc_ld,
  input  logic [ADDR_W-1:0] pc_ld_val,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       IR,
  output logic              ir_valid,
  output logic              busy,
  output logic [ADDR_W-1:0] pc,
  output logic              overrun
`ifdef FETCH_TIMEOUT_EN
  ,
  output logic              fetch_err
`endif
);

  if (TIMEOUT_CYC == 0) begin : g_cfg_check
    $error("fetch_unit: TIMEOUT_CYC must be nonzero");
  end

  fetch_state_e      fstate_q, fstate_nxt;
  logic              mem_req_nxt, ir_valid_nxt, busy_nxt, overrun_nxt;
  logic [ADDR_W-1:0] mem_addr_nxt, pc_nxt;
  logic [15:0]       ir_nxt;
  logic              fetch1_c;
  logic              timeout_c;

  assign fetch1_c = (state == SEQ_FETCH1);

`ifdef FETCH_TIMEOUT_EN
  logic fetch_err_nxt;

  fetch_timeout_ctr #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .clock     (clock),
    .rst_n     (rst_n),
    .run       (fstate_q == F_REQ),
    .expired_c (timeout_c)
  );
`else
  assign timeout_c = 1'b0;
`endif

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      fstate_q  <= F_IDLE;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      IR        <= 16'd0;
      ir_valid  <= 1'b0;
      busy      <= 1'b0;
      pc        <= '0;
      overrun   <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      fetch_err <= 1'b0;
`endif
    end else begin
      fstate_q  <= fstate_nxt;
      mem_req   <= mem_req_nxt;
      mem_addr  <= mem_addr_nxt;
      IR        <= ir_nxt;
      ir_valid  <= ir_valid_nxt;
      busy      <= busy_nxt;
      pc        <= pc_nxt;
      overrun   <= overrun_nxt;
`ifdef FETCH_TIMEOUT_EN
      fetch_err <= fetch_err_nxt;
`endif
    end
  end

  // Next-state and registered-output logic; ack is only looked at in F_REQ, so stray acks are inert.
  always_comb begin
    fstate_nxt   = fstate_q;
    mem_req_nxt  = mem_req;
    mem_addr_nxt = mem_addr;
    ir_nxt       = IR;
    ir_valid_nxt = 1'b0;
    busy_nxt     = busy;
    pc_nxt       = pc;
    overrun_nxt  = overrun | (fetch1_c & busy);
`ifdef FETCH_TIMEOUT_EN
    fetch_err_nxt = fetch_err;
`endif

    case (fstate_q)
      F_IDLE: begin
        if (fetch1_c && !pc_ld) begin
          mem_addr_nxt = pc;
          mem_req_nxt  = 1'b1;
          busy_nxt     = 1'b1;
          fstate_nxt   = F_REQ;
        end
      end
      F_REQ: begin
        if (mem_ack) begin
          ir_nxt       = mem_rdata;
          pc_nxt       = pc + ADDR_W'(1);
          mem_req_nxt  = 1'b0;
          ir_valid_nxt = 1'b1;
          fstate_nxt   = F_DONE;
        end else if (timeout_c) begin
          ir_nxt       = {OP_HALT, 10'd0};
          mem_req_nxt  = 1'b0;
          ir_valid_nxt = 1'b1;
          fstate_nxt   = F_DONE;
`ifdef FETCH_TIMEOUT_EN
          fetch_err_nxt = 1'b1;
`endif
        end
      end
      F_DONE: begin
        busy_nxt   = 1'b0;
        fstate_nxt = F_IDLE;
      end
      default: begin
        mem_req_nxt = 1'b0;
        busy_nxt    = 1'b0;
        fstate_nxt  = F_IDLE;
      end
    endcase

    // A PC load beats the fetch increment on the same edge.
    if (pc_ld) pc_nxt = pc_ld_val;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit (define FETCH_TIMEOUT_EN to also cover the timeout).
module tb_fetch_unit;

  logic        clock = 1'b0;
  logic        rst_n;
  logic [5:0]  state;
  logic        pc_ld;
  logic [7:0]  pc_ld_val;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic [15:0] IR;
  logic        ir_valid;
  logic        busy;
  logic [7:0]  pc;
  logic        overrun;
`ifdef FETCH_TIMEOUT_EN
  logic        fetch_err;
`endif

  int checks = 0;
  int errors = 0;
  int req_cycles;
  int busy_cycles;

  always #5 clock = ~clock;

  fetch_unit #(.ADDR_W(8), .TIMEOUT_CYC(15)) dut (
    .clock     (clock),
    .rst_n     (rst_n),
    .state     (state),
    .pc_ld     (pc_ld),
    .pc_ld_val (pc_ld_val),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .IR        (IR),
    .ir_valid  (ir_valid),
    .busy      (busy),
    .pc        (pc),
    .overrun   (overrun)
`ifdef FETCH_TIMEOUT_EN
    ,
    .fetch_err (fetch_err)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; state = 6'd0; pc_ld = 1'b0; pc_ld_val = 8'h00;
    mem_rdata = 16'h0000; mem_ack = 1'b0;
    tick(); tick();
    check("rst_pc", 32'(pc), 32'h0);
    check("rst_ir", 32'(IR), 32'h0);
    check("rst_addr", 32'(mem_addr), 32'h0);
    check("rst_req", 32'(mem_req), 32'h0);
    check("rst_irv", 32'(ir_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_ovr", 32'(overrun), 32'h0);
    rst_n = 1'b1;
    tick();

    // Basic fetch, ack raised one cycle after the request
    state = 6'd1; mem_rdata = 16'h0400;
    tick();
    state = 6'd0;
    check("t1_req", 32'(mem_req), 32'h1);
    check("t1_addr", 32'(mem_addr), 32'h0);
    check("t1_busy0", 32'(busy), 32'h1);
    check("t1_irv0", 32'(ir_valid), 32'h0);
    busy_cycles = 1;
    tick();
    check("t1_req1", 32'(mem_req), 32'h1);
    check("t1_ir_hold", 32'(IR), 32'h0);
    if (busy) busy_cycles++;
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    if (busy) busy_cycles++;
    check("t1_ir", 32'(IR), 32'h0400);
    check("t1_irv", 32'(ir_valid), 32'h1);
    check("t1_pc", 32'(pc), 32'h1);
    check("t1_req_drop", 32'(mem_req), 32'h0);
    tick();
    if (busy) busy_cycles++;
    check("t1_irv_pulse", 32'(ir_valid), 32'h0);
    check("t1_busy_len", 32'(busy_cycles), 32'd3);
    check("t1_ir_keep", 32'(IR), 32'h0400);
    tick();

    // Ack delayed five cycles
    state = 6'd1; mem_rdata = 16'h1234;
    tick();
    state = 6'd0;
    req_cycles = 0;
    for (int i = 0; i < 5; i++) begin
      if (mem_req) req_cycles++;
      check("t2_ir_hold", 32'(IR), 32'h0400);
      check("t2_busy", 32'(busy), 32'h1);
      tick();
    end
    if (mem_req) req_cycles++;
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("t2_req_len", 32'(req_cycles), 32'd6);
    check("t2_ir", 32'(IR), 32'h1234);
    check("t2_pc", 32'(pc), 32'h2);
    check("t2_req_drop", 32'(mem_req), 32'h0);
    tick();
    check("t2_busy_end", 32'(busy), 32'h0);
    tick();

    // Load PC = FF together with fetch1: load wins, fetch deferred a cycle, PC wraps
    state = 6'd1; pc_ld = 1'b1; pc_ld_val = 8'hFF;
    tick();
    pc_ld = 1'b0;
    check("t3_pc_ld", 32'(pc), 32'hFF);
    check("t3_defer", 32'(mem_req), 32'h0);
    tick();
    state = 6'd0;
    check("t3_req", 32'(mem_req), 32'h1);
    check("t3_addr", 32'(mem_addr), 32'hFF);
    mem_ack = 1'b1; mem_rdata = 16'h0C05;
    tick();
    mem_ack = 1'b0;
    check("t3_wrap", 32'(pc), 32'h00);
    check("t3_ir", 32'(IR), 32'h0C05);
    tick();

    // Stray ack while idle has no effect
    mem_ack = 1'b1; mem_rdata = 16'hFFFF;
    tick(); tick();
    check("t4_ir", 32'(IR), 32'h0C05);
    check("t4_pc", 32'(pc), 32'h00);
    check("t4_irv", 32'(ir_valid), 32'h0);
    check("t4_req", 32'(mem_req), 32'h0);
    mem_ack = 1'b0;
    tick();

    // fetch1 held into F_REQ: single request, sticky overrun
    state = 6'd1;
    tick();
    check("t5_ovr0", 32'(overrun), 32'h0);
    tick();
    state = 6'd0;
    check("t5_ovr", 32'(overrun), 32'h1);
    check("t5_req", 32'(mem_req), 32'h1);
    check("t5_addr", 32'(mem_addr), 32'h00);
    mem_ack = 1'b1; mem_rdata = 16'h0800;
    tick();
    mem_ack = 1'b0;
    check("t5_ir", 32'(IR), 32'h0800);
    check("t5_pc", 32'(pc), 32'h01);
    tick(); tick(); tick();
    check("t5_no_refetch", 32'(mem_req), 32'h0);
    check("t5_sticky", 32'(overrun), 32'h1);

    // Reset mid-fetch: mem_req drops asynchronously, late ack ignored
    state = 6'd1;
    tick();
    state = 6'd0;
    check("t6_req", 32'(mem_req), 32'h1);
    check("t6_addr", 32'(mem_addr), 32'h01);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_req", 32'(mem_req), 32'h0);
    check("t6_ovr_clr", 32'(overrun), 32'h0);
    tick();
    rst_n = 1'b1;
    mem_ack = 1'b1; mem_rdata = 16'hABCD;
    tick();
    check("t6_ir", 32'(IR), 32'h0);
    check("t6_pc", 32'(pc), 32'h0);
    check("t6_irv", 32'(ir_valid), 32'h0);
    tick();
    check("t6_irv2", 32'(ir_valid), 32'h0);
    check("t6_req2", 32'(mem_req), 32'h0);
    mem_ack = 1'b0;
    tick();

`ifdef FETCH_TIMEOUT_EN
    // Timeout: fetch a nonzero word first, then leave a fetch unacked
    state = 6'd1; mem_rdata = 16'h1400;
    tick();
    state = 6'd0; mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    tick(); tick();
    check("t7_pre_ir", 32'(IR), 32'h1400);
    check("t7_pre_err", 32'(fetch_err), 32'h0);
    state = 6'd1;
    tick();
    state = 6'd0;
    req_cycles = 0;
    for (int i = 0; i < 15; i++) begin
      if (mem_req) req_cycles++;
      if (i < 14) tick();
    end
    check("t7_wait_len", 32'(req_cycles), 32'd15);
    check("t7_no_err_yet", 32'(fetch_err), 32'h0);
    tick();
    check("t7_req_drop", 32'(mem_req), 32'h0);
    check("t7_ir_halt", 32'(IR), 32'h0);
    check("t7_irv", 32'(ir_valid), 32'h1);
    check("t7_err", 32'(fetch_err), 32'h1);
    check("t7_pc", 32'(pc), 32'h01);
    tick(); tick();
    check("t7_err_sticky", 32'(fetch_err), 32'h1);
    check("t7_busy_end", 32'(busy), 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
